vga_sync_monitor: RTL



---
 rtl/vga_sync_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// Passive VGA receive checker: recovers pixel coordinates from the sync pulses,
// validates line/frame periods and accumulates a per-frame RGB checksum.
module vga_sync_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        active,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        line_err,
    output logic [7:0]  err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        active_q, active_d;
    logic        frame_done_q, frame_done_d;
    logic        line_err_q, line_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic hs_fall, frame_start;
    logic h_err, v_err, any_err;
    logic hv_active;

    // Sync edge detection and h/v counters; all movement is gated by pix_en.
    always_comb begin
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        h_err       = 1'b0;
        v_err       = 1'b0;
        hs_fall     = pix_en & hs_prev_q & ~hSync;
        frame_start = hs_fall & ~vSync & vs_prev_q;

        if (pix_en) begin
            hs_prev_d = hSync;
            if (hs_fall) begin
                h_cnt_d   = '0;
                h_err     = (state_q != SEARCH) && (h_cnt_q != H_LAST);
                vs_prev_d = vSync;
                if (frame_start) begin
                    v_cnt_d = '0;
                    v_err   = (state_q != SEARCH) && (v_cnt_q != V_LAST);
                end else if (v_cnt_q != CNT_MAX) begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                // A missing fall is only meaningful once a frame has been seen.
                h_err = (state_q != SEARCH) && (h_cnt_q == H_LAST);
                if (h_cnt_q != CNT_MAX) begin
                    h_cnt_d = h_cnt_q + 10'd1;
                end
            end
        end
        any_err = h_err | v_err;
    end

    // Coordinates describe the pixel sampled now, i.e. the post-update counts.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        active_d  = active_q;
        hv_active = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                    (v_cnt_d >= V_START) && (v_cnt_d < V_END);
        if (pix_en) begin
            active_d = hv_active && (state_q == LOCKED);
            if (hv_active) begin
                x_d = h_cnt_d - H_START;
                y_d = 9'(v_cnt_d - V_START);
            end
        end
    end

    // Lock state machine, error bookkeeping and frame checksum.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        frame_sum_d  = frame_sum_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        err_count_d  = err_count_q;

        if (pix_en) begin
            if (frame_start) begin
                acc_d = '0;
            end else if (active_d) begin
                acc_d = acc_q + {4'd0, VGA_R, VGA_G, VGA_B};
            end

            if (any_err) begin
                state_d    = SEARCH;
                line_err_d = 1'b1;
                if (err_count_q != 8'hff) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else if (frame_start) begin
                case (state_q)
                    SEARCH: state_d = TRACK;
                    TRACK, LOCKED: begin
                        state_d      = LOCKED;
                        frame_sum_d  = acc_q;
                        frame_done_d = 1'b1;
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            acc_q        <= '0;
            frame_sum_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            acc_q        <= acc_d;
            frame_sum_q  <= frame_sum_d;
            x_q          <= x_d;
            y_q          <= y_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign active     = active_q;
    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign line_err   = line_err_q;
    assign err_count  = err_count_q;

endmodule
